// File: rtl/wb_macro_mux_pkg.sv
// Shared types and constants for the Wishbone macro multiplexer.
// Holds the FSM state encoding, the error word and the slot-field width helper.
package wb_macro_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    // Slot field width; never below one bit so the decode slice stays legal.
    function automatic int calc_sel_w(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/wb_mux_timer.sv
// Loadable up-counter that stops at TIMEOUT and flags terminal count.
// Used to bound how long the mux waits for a macro ack.
module wb_mux_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    output logic tc
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TC_VAL = TW'(TIMEOUT);

    logic [TW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (inc && !tc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/wb_macro_mux.sv
// Shares the Caravel user Wishbone slave port between N_MACROS macros.
// Decodes a slot from the address, gates by enable, and bounds each access with a timeout.
module wb_macro_mux
    import wb_macro_mux_pkg::*;
#(
    parameter int          N_MACROS = 4,
    parameter logic [7:0]  BASE_HI  = 8'h30,
    parameter int          SLOT_LSB = 20,
    parameter int          TIMEOUT  = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    input  logic [N_MACROS-1:0]      enable_i,
    output logic [N_MACROS-1:0]      m_cyc_o,
    output logic [N_MACROS-1:0]      m_stb_o,
    output logic                     m_we_o,
    output logic [3:0]               m_sel_o,
    output logic [31:0]              m_adr_o,
    output logic [31:0]              m_dat_o,
    input  logic [N_MACROS-1:0]      m_ack_i,
    input  logic [32*N_MACROS-1:0]   m_dat_i,
    output logic                     busy_o,
    output logic                     timeout_o,
    output logic [7:0]               err_cnt_o
);

    localparam int SEL_W = calc_sel_w(N_MACROS);

    state_t               state;
    logic [SEL_W-1:0]     slot_q;
    logic [SEL_W-1:0]     req_slot;
    logic [N_MACROS-1:0]  req_onehot;
    logic [N_MACROS-1:0]  stb_q;
    logic                 hit;
    logic                 slot_ok;
    logic                 sel_ack;
    logic [31:0]          sel_dat;
    logic                 timer_tc;

    // Request decode; slots beyond N_MACROS never match, so they fall through to ERR.
    always_comb begin
        req_slot   = wbs_adr_i[SLOT_LSB +: SEL_W];
        hit        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_HI);
        slot_ok    = 1'b0;
        req_onehot = '0;
        for (int i = 0; i < N_MACROS; i++) begin
            if (req_slot == SEL_W'(i)) begin
                slot_ok       = enable_i[i];
                req_onehot[i] = 1'b1;
            end
        end
    end

    // Only the latched slot's ack and data are visible to the FSM.
    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < N_MACROS; i++) begin
            if (slot_q == SEL_W'(i)) begin
                sel_ack = m_ack_i[i];
                sel_dat = m_dat_i[32*i +: 32];
            end
        end
    end

    wb_mux_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .load (state == ST_IDLE),
        .inc  (state == ST_WAIT),
        .tc   (timer_tc)
    );

    // Transaction FSM; wbs_ack_o is raised on entry to RESP and dropped on exit.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            slot_q    <= '0;
            stb_q     <= '0;
            m_we_o    <= 1'b0;
            m_sel_o   <= '0;
            m_adr_o   <= '0;
            m_dat_o   <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            timeout_o <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            wbs_ack_o <= 1'b0;
            timeout_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        if (slot_ok) begin
                            slot_q  <= req_slot;
                            stb_q   <= req_onehot;
                            m_we_o  <= wbs_we_i;
                            m_sel_o <= wbs_sel_i;
                            m_adr_o <= wbs_adr_i;
                            m_dat_o <= wbs_dat_i;
                            state   <= ST_WAIT;
                        end else begin
                            state <= ST_ERR;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!wbs_cyc_i) begin
                        stb_q <= '0;
                        state <= ST_IDLE;
                    end else if (sel_ack) begin
                        wbs_dat_o <= sel_dat;
                        wbs_ack_o <= 1'b1;
                        stb_q     <= '0;
                        state     <= ST_RESP;
                    end else if (timer_tc) begin
                        wbs_dat_o <= ERR_WORD;
                        wbs_ack_o <= 1'b1;
                        timeout_o <= 1'b1;
                        stb_q     <= '0;
                        if (err_cnt_o != 8'hFF) begin
                            err_cnt_o <= err_cnt_o + 8'd1;
                        end
                        state <= ST_RESP;
                    end
                end
                ST_ERR: begin
                    wbs_dat_o <= ERR_WORD;
                    wbs_ack_o <= 1'b1;
                    if (err_cnt_o != 8'hFF) begin
                        err_cnt_o <= err_cnt_o + 8'd1;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_cyc_o = stb_q;
    assign m_stb_o = stb_q;
    assign busy_o  = (state != ST_IDLE);

endmodule

// File: tb/tb_wb_macro_mux.sv
// Directed bench for wb_macro_mux: vector table plus abort, saturation and reset sequences.
// Cycle 0 is the cycle the host request is first presented; cycle k follows the k-th rising edge.
module tb_wb_macro_mux;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wbs_stb_i = 1'b0;
    logic         wbs_cyc_i = 1'b0;
    logic         wbs_we_i = 1'b0;
    logic [3:0]   wbs_sel_i = '0;
    logic [31:0]  wbs_adr_i = '0;
    logic [31:0]  wbs_dat_i = '0;
    logic         wbs_ack_o;
    logic [31:0]  wbs_dat_o;
    logic [3:0]   enable_i = '0;
    logic [3:0]   m_cyc_o;
    logic [3:0]   m_stb_o;
    logic         m_we_o;
    logic [3:0]   m_sel_o;
    logic [31:0]  m_adr_o;
    logic [31:0]  m_dat_o;
    logic [3:0]   m_ack_i = '0;
    logic [127:0] m_dat_i = '0;
    logic         busy_o;
    logic         timeout_o;
    logic [7:0]   err_cnt_o;

    always #5 clk = ~clk;

    wb_macro_mux #(
        .N_MACROS (4),
        .BASE_HI  (8'h30),
        .SLOT_LSB (20),
        .TIMEOUT  (255)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .enable_i  (enable_i),
        .m_cyc_o   (m_cyc_o),
        .m_stb_o   (m_stb_o),
        .m_we_o    (m_we_o),
        .m_sel_o   (m_sel_o),
        .m_adr_o   (m_adr_o),
        .m_dat_o   (m_dat_o),
        .m_ack_i   (m_ack_i),
        .m_dat_i   (m_dat_i),
        .busy_o    (busy_o),
        .timeout_o (timeout_o),
        .err_cnt_o (err_cnt_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [3:0]  en;
        logic [31:0] mdat;
        int          ack_at;   // macro ack cycle, 0 = never
        int          exp_ack;  // wbs_ack_o cycle, 0 = none
        logic        chk_dat;
        logic [31:0] exp_dat;
        logic [7:0]  exp_err;
        logic [3:0]  exp_stb;
        int          exp_to;
    } vec_t;

    vec_t vecs[8];

    int pass_cnt  = 0;
    int total_cnt = 0;

    int          ack_cyc;
    logic [31:0] dat_got;
    logic [3:0]  stb_seen;
    int          to_cnt;
    int          busy_cnt;
    logic        bc_valid;
    logic        bc_we;
    logic [3:0]  bc_sel;
    logic [31:0] bc_adr;
    logic [31:0] bc_dat;

    task automatic check_output(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Host presents one request; a bench macro on the addressed slot acks in cycle ack_at.
    // A decoy ack is driven on a neighbouring slot every cycle to prove it is ignored.
    task automatic apply_stimulus(input vec_t v, input int max_cycles);
        int slot;
        int decoy;
        slot  = int'(v.adr[21:20]);
        decoy = slot ^ 1;
        @(negedge clk);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = v.we;
        wbs_sel_i = v.sel;
        wbs_adr_i = v.adr;
        wbs_dat_i = v.dat;
        enable_i  = v.en;
        for (int i = 0; i < 4; i++) begin
            m_dat_i[32*i +: 32] = 32'hBAD0_0000 | 32'(i);
        end
        m_dat_i[32*slot +: 32] = v.mdat;
        m_ack_i  = '0;
        ack_cyc  = 0;
        dat_got  = '0;
        stb_seen = '0;
        to_cnt   = 0;
        busy_cnt = 0;
        bc_valid = 1'b0;
        for (int c = 1; c <= max_cycles; c++) begin
            @(negedge clk);
            stb_seen = stb_seen | m_stb_o;
            if (m_stb_o != 4'b0 && !bc_valid) begin
                bc_valid = 1'b1;
                bc_we    = m_we_o;
                bc_sel   = m_sel_o;
                bc_adr   = m_adr_o;
                bc_dat   = m_dat_o;
            end
            if (timeout_o) to_cnt++;
            if (busy_o) busy_cnt++;
            if (wbs_ack_o) begin
                ack_cyc = c;
                dat_got = wbs_dat_o;
                break;
            end
            m_ack_i = '0;
            m_ack_i[decoy] = 1'b1;
            if (v.ack_at == c && m_stb_o[slot]) begin
                m_ack_i[slot] = 1'b1;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        m_ack_i   = '0;
    endtask

    initial begin
        // we, adr, dat, sel, en, mdat, ack_at, exp_ack, chk_dat, exp_dat, exp_err, exp_stb, exp_to
        vecs[0] = '{1'b0, 32'h3020_0000, 32'h0, 4'hF, 4'hF, 32'h1234_5678, 4, 5, 1'b1, 32'h1234_5678, 8'd0, 4'b0100, 0};
        vecs[1] = '{1'b1, 32'h3000_0010, 32'hA5A5_A5A5, 4'hF, 4'hF, 32'h0, 1, 2, 1'b0, 32'h0, 8'd0, 4'b0001, 0};
        vecs[2] = '{1'b0, 32'h3010_0000, 32'h0, 4'hF, 4'b1101, 32'h1111_1111, 1, 2, 1'b1, 32'hDEAD_BEEF, 8'd1, 4'b0000, 0};
        vecs[3] = '{1'b0, 32'h2000_0000, 32'h0, 4'hF, 4'hF, 32'h2222_2222, 1, 0, 1'b0, 32'h0, 8'd1, 4'b0000, 0};
        vecs[4] = '{1'b0, 32'h3030_0004, 32'h0, 4'h3, 4'hF, 32'hCAFE_F00D, 1, 2, 1'b1, 32'hCAFE_F00D, 8'd1, 4'b1000, 0};
        vecs[5] = '{1'b0, 32'h3030_0000, 32'h0, 4'hF, 4'b0111, 32'h3333_3333, 1, 2, 1'b1, 32'hDEAD_BEEF, 8'd2, 4'b0000, 0};
        vecs[6] = '{1'b0, 32'h3010_0020, 32'h0, 4'hF, 4'hF, 32'h4444_4444, 0, 257, 1'b1, 32'hDEAD_BEEF, 8'd3, 4'b0010, 1};
        vecs[7] = '{1'b0, 32'h3000_0008, 32'h0, 4'hF, 4'hF, 32'h7777_0000, 256, 257, 1'b1, 32'h7777_0000, 8'd3, 4'b0001, 0};

        // Reset state
        repeat (2) @(negedge clk);
        check_output("reset ack", 32'(wbs_ack_o), 32'd0);
        check_output("reset dat", wbs_dat_o, 32'h0);
        check_output("reset stb", 32'(m_stb_o), 32'd0);
        check_output("reset cyc", 32'(m_cyc_o), 32'd0);
        check_output("reset busy", 32'(busy_o), 32'd0);
        check_output("reset timeout", 32'(timeout_o), 32'd0);
        check_output("reset err_cnt", 32'(err_cnt_o), 32'd0);
        rst = 1'b0;

        for (int n = 0; n < 8; n++) begin
            apply_stimulus(vecs[n], (vecs[n].exp_ack == 0) ? 8 : 300);
            check_output($sformatf("v%0d ack cycle", n), 32'(ack_cyc), 32'(vecs[n].exp_ack));
            check_output($sformatf("v%0d strobes", n), 32'(stb_seen), 32'(vecs[n].exp_stb));
            check_output($sformatf("v%0d timeout pulses", n), 32'(to_cnt), 32'(vecs[n].exp_to));
            if (vecs[n].chk_dat) begin
                check_output($sformatf("v%0d data", n), dat_got, vecs[n].exp_dat);
            end
            if (vecs[n].exp_stb != 4'b0) begin
                check_output($sformatf("v%0d m_we", n), 32'(bc_we), 32'(vecs[n].we));
                check_output($sformatf("v%0d m_sel", n), 32'(bc_sel), 32'(vecs[n].sel));
                check_output($sformatf("v%0d m_adr", n), bc_adr, vecs[n].adr);
                check_output($sformatf("v%0d m_dat", n), bc_dat, vecs[n].dat);
            end
            if (vecs[n].exp_ack == 0) begin
                check_output($sformatf("v%0d busy cycles", n), 32'(busy_cnt), 32'd0);
            end
            @(negedge clk);
            check_output($sformatf("v%0d ack single", n), 32'(wbs_ack_o), 32'd0);
            check_output($sformatf("v%0d idle after", n), 32'(busy_o), 32'd0);
            check_output($sformatf("v%0d err_cnt", n), 32'(err_cnt_o), 32'(vecs[n].exp_err));
        end

        // Host abort while waiting: strobes drop next cycle, no ack, no error
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 32'h3020_0000; enable_i = 4'hF; m_ack_i = '0;
        repeat (2) @(negedge clk);
        check_output("abort stb before", 32'(m_stb_o), 32'b0100);
        enable_i = 4'h0;
        @(negedge clk);
        check_output("enable drop no abort", 32'(m_stb_o), 32'b0100);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk);
        check_output("abort stb after", 32'(m_stb_o), 32'd0);
        check_output("abort busy", 32'(busy_o), 32'd0);
        check_output("abort ack", 32'(wbs_ack_o), 32'd0);
        @(negedge clk);
        check_output("abort no late ack", 32'(wbs_ack_o), 32'd0);
        check_output("abort err_cnt", 32'(err_cnt_o), 32'd3);

        // Error counter saturation through 300 disabled-slot accesses
        begin
            int bad;
            bad = 0;
            for (int k = 0; k < 300; k++) begin
                apply_stimulus(vecs[2], 10);
                if (ack_cyc != 2 || dat_got != 32'hDEAD_BEEF) bad++;
                @(negedge clk);
            end
            check_output("saturation acks", 32'(bad), 32'd0);
            check_output("saturation err_cnt", 32'(err_cnt_o), 32'd255);
        end

        // Reset asserted in WAIT drops strobes immediately
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 32'h3030_0000; enable_i = 4'hF; m_ack_i = '0;
        repeat (2) @(negedge clk);
        check_output("rst stb before", 32'(m_stb_o), 32'b1000);
        rst = 1'b1;
        #1;
        check_output("rst stb immediate", 32'(m_stb_o), 32'd0);
        check_output("rst busy", 32'(busy_o), 32'd0);
        check_output("rst err_cnt", 32'(err_cnt_o), 32'd0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk);
        check_output("rst ack", 32'(wbs_ack_o), 32'd0);
        rst = 1'b0;

        apply_stimulus(vecs[0], 20);
        check_output("post-reset ack cycle", 32'(ack_cyc), 32'd5);
        check_output("post-reset data", dat_got, 32'h1234_5678);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
